// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues instruction-memory reads and buffers returned words in a prefetch queue for the decoder.
// Define FETCH_STATS_EN to add saturating stat_fetched / stat_flushed counters.
module fetch_unit #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INSTR_W  = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter int unsigned        PC_STEP  = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic                     imem_req,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic [INSTR_W-1:0]       instr,
  output logic [ADDR_W-1:0]        instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   q_count
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]              stat_fetched,
  output logic [15:0]              stat_flushed
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic               inflight_q, inflight_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;

  logic [INSTR_W-1:0] mem_instr [DEPTH];
  logic [ADDR_W-1:0]  mem_pc    [DEPTH];

  logic               pop, push, issue;
  logic [CNT_W-1:0]   occ_now, occ_after_pop, remain;

  // The in-flight word is part of occupancy so every issued read has a slot reserved when it returns.
  assign pop           = instr_valid_q & instr_ready;
  assign push          = inflight_q & ~redirect;
  assign occ_now       = count_q + CNT_W'(inflight_q);
  assign occ_after_pop = occ_now - CNT_W'(pop);
  assign remain        = count_q - CNT_W'(pop);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN: begin
        issue = (occ_after_pop < CNT_W'(DEPTH));
        if ((occ_now == CNT_W'(DEPTH)) && !pop) state_d = ST_HOLD;
      end
      ST_HOLD: if (pop) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
    // A redirect cycle issues nothing: the first fetch of the new stream is redirect_pc, next cycle.
    if (redirect) begin
      state_d = ST_RUN;
      issue   = 1'b0;
    end
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d          = pc_q + ADDR_W'(PC_STEP);
      inflight_pc_d = pc_q;
    end
  end

  assign inflight_d = issue;

  always_comb begin
    rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d      = wr_ptr_q + PTR_W'(push);
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (count_d != '0) begin
      // When the queue drains this cycle the new head is the word arriving right now.
      if (remain == '0) begin
        instr_d    = imem_rdata;
        instr_pc_d = inflight_pc_q;
      end else begin
        instr_d    = mem_instr[rd_ptr_d];
        instr_pc_d = mem_pc[rd_ptr_d];
      end
    end
    instr_valid_d = (count_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // NOTE: queue storage is not reset; count/pointers guarantee no entry is read before it is written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr_q] <= imem_rdata;
      mem_pc[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  assign imem_addr   = pc_q;
  assign imem_req    = issue;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign q_count     = count_q;

`ifdef FETCH_STATS_EN
  logic [15:0] fetched_q, fetched_d, flushed_q, flushed_d;
  logic [16:0] flushed_sum;

  // Flushed = entries still queued after any legal pop, plus the stale word returning this cycle.
  always_comb begin
    fetched_d   = fetched_q;
    flushed_d   = flushed_q;
    flushed_sum = {1'b0, flushed_q} + 17'(remain) + 17'(inflight_q);
    if (push && (fetched_q != 16'hFFFF)) fetched_d = fetched_q + 16'd1;
    if (redirect) flushed_d = flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_flushed = flushed_q;
`endif

endmodule
